// File: rtl/gf_div_seq_pkg.sv
// Shared constants and types for the sequential GF(2^8) divider.
package gf_div_seq_pkg;

    localparam logic [7:0]  GF_POLY   = 8'h63;
    localparam int unsigned ITERS     = 7;
    localparam logic [2:0]  LAST_ITER = 3'(ITERS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSqr,
        StMul
    } state_e;

endpackage

// File: rtl/gf_mul_comb.sv
// Combinational GF(2^8) multiplier: shift-and-add over the bits of b, reduced by POLY.
module gf_mul_comb #(
    parameter logic [7:0] POLY = 8'h63
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] sh;

    always_comb begin
        p  = '0;
        sh = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY) : {sh[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/gf_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^254 via 7 square/multiply pairs on one multiplier.
module gf_div_seq
    import gf_div_seq_pkg::*;
#(
    parameter logic [7:0] POLY = GF_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic       dz
);

    state_e     state_q, state_d;
    logic [7:0] sq_q, sq_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dz_r_q, dz_r_d;
    logic [7:0] quo_q, quo_d;
    logic       dz_q, dz_d;
    logic       done_q, done_d;

    logic [7:0] mul_a;
    logic [7:0] mul_p;

    gf_mul_comb #(
        .POLY(POLY)
    ) u_mul (
        .a(mul_a),
        .b(sq_q),
        .p(mul_p)
    );

    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dz_r_d  = dz_r_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        mul_a   = acc_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sq_d    = b;
                    acc_d   = a;
                    dz_r_d  = (b == 8'h00);
                    cnt_d   = '0;
                    state_d = StSqr;
                end
            end
            StSqr: begin
                mul_a   = sq_q;
                sq_d    = mul_p;
                state_d = StMul;
            end
            StMul: begin
                mul_a = acc_q;
                acc_d = mul_p;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    quo_d   = mul_p;
                    dz_d    = dz_r_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StSqr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dz_r_q  <= 1'b0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dz_r_q  <= dz_r_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign q    = quo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_gf_div_seq.sv
// Randomized scoreboard bench for gf_div_seq against a polynomial-arithmetic reference model.
module tb_gf_div_seq;
    import gf_div_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b, q;
    logic       busy, done, dz;
    logic [7:0] ma, mb, mp;

    always #5 clk = ~clk;

    gf_div_seq #(.POLY(GF_POLY)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .dz(dz)
    );

    gf_mul_comb #(.POLY(GF_POLY)) u_mul_chk (.a(ma), .b(mb), .p(mp));

    typedef struct {
        logic [7:0]  q;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full carry-less product, then long division by x^8+x^6+x^5+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) prod = prod ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h0163 << (i - 8));
        return prod[7:0];
    endfunction

    // Reference: find the inverse by search, 0 for a zero divisor.
    function automatic logic [7:0] ref_div(input logic [7:0] x, input logic [7:0] y);
        if (y == 8'h00) return 8'h00;
        for (int i = 1; i < 256; i++)
            if (ref_mul(y, 8'(i)) == 8'h01) return ref_mul(x, 8'(i));
        return 8'hxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: done=1 with nothing pending, q=%0h dz=%0b", q, dz);
            end else begin
                e = sb.pop_front();
                check("q", 32'(q), 32'(e.q));
                check("dz", 32'(dz), 32'(e.dz));
                check("latency", cyc, e.cyc);
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge; waits for idle, presents one request, returns after the accept edge.
    task automatic issue(input logic [7:0] ai, input logic [7:0] bi,
                         input logic [7:0] eq, input logic edz);
        int unsigned w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_wait: busy=%0b after %0d cycles, expected 0", busy, w);
        end
        a = ai;
        b = bi;
        start = 1'b1;
        sb.push_back('{q: eq, dz: edz, cyc: cyc + 15});
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic issue_rand(input logic [7:0] ai, input logic [7:0] bi);
        issue(ai, bi, ref_div(ai, bi), bi == 8'h00);
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] q_hold;
        int unsigned k, w;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ma    = '0;
        mb    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        issue(8'h01, 8'h02, 8'hB1, 1'b0);
        drain();
        issue(8'h02, 8'hB1, 8'h04, 1'b0);
        issue(8'h5A, 8'h5A, 8'h01, 1'b0);
        issue(8'h37, 8'h01, 8'h37, 1'b0);
        issue(8'h45, 8'h00, 8'h00, 1'b1);
        drain();

        // start pulses during busy must be ignored.
        issue(8'h03, 8'h07, ref_div(8'h03, 8'h07), 1'b0);
        q_hold = q;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("q_hold_busy", 32'(q), 32'(q_hold));
        drain();

        // start held high: a new op in every done cycle.
        start = 1'b1;
        k = 0;
        w = 0;
        while (k < 10 && w < 400) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (!busy) begin
                sb.push_back('{q: ref_div(a, b), dz: b == 8'h00, cyc: cyc + 15});
                k++;
            end
            @(negedge clk);
            w++;
        end
        start = 1'b0;
        drain();

        // Reset mid-operation aborts without a done pulse.
        issue(8'h37, 8'h01, 8'h37, 1'b0);
        drain();
        issue_rand(8'h9C, 8'h2B);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(q), 32'd0);
        check("abort_dz", 32'(dz), 32'd0);
        repeat (20) @(negedge clk);
        issue(8'h01, 8'h02, 8'hB1, 1'b0);
        drain();

        // Every divisor with a random dividend, back to back.
        for (int i = 0; i < 256; i++) issue_rand(8'($urandom), 8'(i));
        drain();

        for (int i = 0; i < 60; i++) issue_rand(8'($urandom), 8'($urandom));
        drain();

        // Exhaustive multiplier check against the reference product.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                ma = 8'(i);
                mb = 8'(j);
                #1;
                check("mul", 32'(mp), 32'(ref_mul(8'(i), 8'(j))));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_div_seq.md
GF_DIV_SEQ -- requirements
Module: gf_div_seq

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h63, meaning the low byte of the field modulus x^8+x^6+x^5+x+1 (0x163) used by SEED.
REQ-002 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 8 bits: dividend.
REQ-006 The block SHALL have port b, input, 8 bits: divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port q, output, 8 bits: quotient a*b^-1 in GF(2^8), held until the next done.
REQ-010 The block SHALL have port dz, output, 1 bit: divide-by-zero flag, updated with done.

Function
REQ-011 The block SHALL compute q = a * b^254 mod (x^8 | POLY), which equals a/b for b!=0 and 0 for b=0.
REQ-012 The block SHALL implement the FSM states IDLE, SQR and MUL.
REQ-013 In IDLE with start=1, the block SHALL, at that edge, capture sq<=b, acc<=a, dz_r<=(b==0) and cnt<=0, then enter SQR; busy SHALL be high from the next cycle.
REQ-014 In SQR, the block SHALL set sq<=sq*sq and go to MUL.
REQ-015 In MUL, the block SHALL set acc<=acc*sq and cnt<=cnt+1; if cnt==6 it SHALL go to IDLE, otherwise back to SQR (7 SQR/MUL pairs, exponent 2+4+...+128=254).
REQ-016 On the final MUL edge, the block SHALL load q<=acc*sq and dz<=dz_r and assert done for exactly the following cycle, with busy low in that same cycle.
REQ-017 Latency SHALL be 14 clocks from the start-accept edge to the edge that raises done; throughput SHALL be one division per 15 cycles.
REQ-018 The block SHALL ignore start while busy; a and b need only be valid on the accept edge.
REQ-019 The block SHALL accept start asserted in the done cycle (IDLE), giving back-to-back operation.
REQ-020 The datapath SHALL use exactly one time-shared combinational GF(2^8) multiplier; its operands are muxed as (sq,sq) in SQR and (acc,sq) in MUL.
REQ-021 Each multiply SHALL be a shift-and-add over 8 bits of the second operand, xoring POLY after each left shift that carries out bit 7.
REQ-022 b=0 SHALL run the full 14 cycles and yield q=0x00 with dz=1; any other b SHALL yield dz=0.

Reset
REQ-023 rst=1 SHALL force state IDLE, cnt=0, sq=acc=0, q=0x00, dz=0, done=0 and busy=0 on the next edge.
REQ-024 rst SHALL take priority over start and SHALL abort an in-flight division with no done pulse.
REQ-025 After rst falls, the first start SHALL behave as from power-up.

Structure
REQ-026 The shared SEED package SHALL hold the GF_POLY constant (8'h63), the FSM state typedef and the iteration count constant (7).
REQ-027 The multiplier SHALL be a single sub-module, gf_mul_comb (8-bit a, b in, p out, POLY parameter), instantiated once.

Verification
REQ-028 a=0x01, b=0x02, start pulse -> done exactly 14 clocks after the accept edge, q=0xB1, dz=0.
REQ-029 a=0x02, b=0xB1 -> q=0x04; a=0x5A, b=0x5A -> q=0x01; a=0x37, b=0x01 -> q=0x37.
REQ-030 a=0x45, b=0x00 -> q=0x00, dz=1, one done pulse after 14 clocks.
REQ-031 start held high continuously with new a/b each op -> done every 15 cycles; start pulses during busy are ignored (no extra done, q unchanged).
REQ-032 rst asserted 5 cycles into an operation -> busy=0, done never pulses, q=0x00; the following start (a=0x01, b=0x02) -> q=0xB1.
REQ-033 Exhaustive a, b in 0..255 -> gf_mul_comb(q, b)==a for every b!=0, checked against a reference model.
